// File: rtl/round_timer_pkg.sv
// round_timer_pkg: shared state type and counter-width helper for the
// round timer controller and its prescalers.
package round_timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   // Bits needed to hold 0..div-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled cycles 0..DIV-1 and flags the last one.
// clear has priority over enable; the count holds while enable is low.
module tick_prescaler
   import round_timer_pkg::*;
#(
   parameter int unsigned DIV = 4
)(
   input  logic clk,
   input  logic resetN,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned W = cnt_width(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // Free-running modulo-DIV count while enabled, cleared on demand.
   always_ff @(posedge clk) begin
      if (!resetN || clear)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
   end

   assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: run/pause/expire control for an external BCD down
// counter. Optional low-time warning and blink output is built only when
// the macro ROUND_TIMER_WARN_EN is defined; otherwise warn/warn_blink are 0.
module round_timer_ctrl
   import round_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50000000,
   parameter logic [3:0]  WARN_H    = 4'h1,
   parameter logic [3:0]  WARN_L    = 4'h0,
   parameter int unsigned BLINK_DIV = 25000000
)(
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic       pause_toggle,
   input  logic       abort,
   input  logic [3:0] countL,
   input  logic [3:0] countH,
   input  logic       cnt_tc,
   output logic       cnt_loadN,
   output logic       cnt_enable,
   output logic       running,
   output logic       paused,
   output logic       expired,
   output logic       time_up,
   output logic       warn,
   output logic       warn_blink
);

   state_t state, state_nxt;
   logic   tick_tc;
   logic   exp_first;

   // Next state: abort beats start beats terminal count beats pause toggle.
   always_comb begin
      state_nxt = state;
      if (abort)
         state_nxt = ST_IDLE;
      else if (start)
         state_nxt = ST_LOAD;
      else begin
         case (state)
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN: begin
               if (cnt_tc)
                  state_nxt = ST_EXPIRED;
               else if (pause_toggle)
                  state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (pause_toggle) state_nxt = ST_RUN;
            default:  state_nxt = state;
         endcase
      end
   end

   // State register plus a flag marking the first cycle of EXPIRED.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state     <= ST_IDLE;
         exp_first <= 1'b0;
      end else begin
         state     <= state_nxt;
         exp_first <= (state == ST_RUN) && (state_nxt == ST_EXPIRED);
      end
   end

   // Tick prescaler counts in RUN, holds in PAUSE, cleared elsewhere.
   tick_prescaler #(.DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .resetN (resetN),
      .clear  (!(state == ST_RUN || state == ST_PAUSE)),
      .enable (state == ST_RUN),
      .tc     (tick_tc)
   );

   // Strobes are suppressed when the same cycle redirects the FSM.
   assign cnt_loadN  = !((state == ST_LOAD) && !abort);
   assign cnt_enable = (state == ST_RUN) && tick_tc && !cnt_tc && !abort && !start;
   assign running    = (state == ST_RUN);
   assign paused     = (state == ST_PAUSE);
   assign time_up    = (state == ST_EXPIRED);
   assign expired    = exp_first;

`ifdef ROUND_TIMER_WARN_EN
   logic warn_lvl;
   logic blink_tc;
   logic blink_q;

   // BCD digits compare correctly as one 8-bit number, tens in the top nibble.
   assign warn_lvl = (state == ST_RUN || state == ST_PAUSE) && !cnt_tc &&
                     ({countH, countL} <= {WARN_H, WARN_L});

   tick_prescaler #(.DIV(BLINK_DIV)) u_blink (
      .clk    (clk),
      .resetN (resetN),
      .clear  (!warn_lvl),
      .enable (warn_lvl),
      .tc     (blink_tc)
   );

   // Blink phase toggles once per BLINK_DIV warning cycles, restarts low.
   always_ff @(posedge clk) begin
      if (!resetN || !warn_lvl)
         blink_q <= 1'b0;
      else if (blink_tc)
         blink_q <= !blink_q;
   end

   assign warn       = warn_lvl;
   assign warn_blink = blink_q && warn_lvl;
`else
   logic unused_cfg;
   assign unused_cfg = ^{countH, countL, WARN_H, WARN_L, BLINK_DIV[0]};
   assign warn       = 1'b0;
   assign warn_blink = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb_round_timer_ctrl: directed and random stimulus against a behavioural
// model of the round timer, including a model of the external BCD counter.
module tb_round_timer_ctrl;

   localparam int unsigned TICK_DIV  = 4;
   localparam int unsigned BLINK_DIV = 3;
   localparam int          WARN_VAL  = 10;

   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4;

   logic clk = 1'b0;
   logic resetN, start, pause_toggle, abort;
   logic [3:0] countL, countH;
   logic cnt_tc;
   logic cnt_loadN, cnt_enable, running, paused, expired, time_up, warn, warn_blink;

   round_timer_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .WARN_H    (4'h1),
      .WARN_L    (4'h0),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .start        (start),
      .pause_toggle (pause_toggle),
      .abort        (abort),
      .countL       (countL),
      .countH       (countH),
      .cnt_tc       (cnt_tc),
      .cnt_loadN    (cnt_loadN),
      .cnt_enable   (cnt_enable),
      .running      (running),
      .paused       (paused),
      .expired      (expired),
      .time_up      (time_up),
      .warn         (warn),
      .warn_blink   (warn_blink)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cycle_n = 0;

   // reference model state
   int mode, rc, wc, load_val, cval;
   bit first_exp;

   // last observed DUT outputs
   logic obs_en, obs_exp, obs_loadN, obs_warn, obs_blink;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle_n, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check against the model, then advance the model.
   task automatic cyc(input logic a, input logic s, input logic p, input logic r);
      logic tc, e_loadN, e_en, e_warn, e_blink;
      int nm;
      @(negedge clk);
      abort = a; start = s; pause_toggle = p; resetN = r;
      countH = 4'(cval / 10);
      countL = 4'(cval % 10);
      cnt_tc = (cval == 0);
      tc = (cval == 0);
      #1;
      e_loadN = !(mode == M_LOAD && !a);
      e_en    = (mode == M_RUN) && (rc == TICK_DIV - 1) && !tc && !a && !s;
`ifdef ROUND_TIMER_WARN_EN
      e_warn  = (mode == M_RUN || mode == M_PAUSE) && !tc && (cval <= WARN_VAL);
      e_blink = e_warn && (((wc / BLINK_DIV) % 2) == 1);
`else
      e_warn  = 1'b0;
      e_blink = 1'b0;
`endif
      chk("cnt_loadN",  cnt_loadN,  e_loadN);
      chk("cnt_enable", cnt_enable, e_en);
      chk("running",    running,    mode == M_RUN);
      chk("paused",     paused,     mode == M_PAUSE);
      chk("time_up",    time_up,    mode == M_EXP);
      chk("expired",    expired,    first_exp);
      chk("warn",       warn,       e_warn);
      chk("warn_blink", warn_blink, e_blink);
      obs_en = cnt_enable; obs_exp = expired; obs_loadN = cnt_loadN;
      obs_warn = warn; obs_blink = warn_blink;
      @(posedge clk);
      cycle_n++;
      // external counter: untouched by reset
      if (!e_loadN) cval = load_val;
      else if (e_en) cval = cval - 1;
      if (!r) begin
         mode = M_IDLE; rc = 0; wc = 0; first_exp = 0;
      end else begin
         nm = mode;
         if (a) nm = M_IDLE;
         else if (s) nm = M_LOAD;
         else if (mode == M_LOAD) nm = M_RUN;
         else if (mode == M_RUN) begin
            if (tc) nm = M_EXP;
            else if (p) nm = M_PAUSE;
         end else if (mode == M_PAUSE && p) nm = M_RUN;
         if (mode == M_RUN) rc = (rc + 1) % TICK_DIV;
         else if (mode != M_PAUSE) rc = 0;
         first_exp = (mode == M_RUN) && (nm == M_EXP);
         wc = e_warn ? wc + 1 : 0;
         mode = nm;
      end
   endtask

   // Load 03 and run to expiry; strobe positions counted from first RUN cycle.
   task automatic run_003(input string tag);
      int strobes[$];
      int exp_k, exp_cnt;
      strobes = {};
      exp_k = -1; exp_cnt = 0;
      load_val = 3;
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      chk({tag, "_load_strobe"}, obs_loadN, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         cyc(0, 0, 0, 1);
         if (obs_en) strobes.push_back(k);
         if (obs_exp) begin exp_k = k; exp_cnt++; end
      end
      chk_int({tag, "_n_strobes"}, strobes.size(), 3);
      if (strobes.size() == 3) begin
         chk_int({tag, "_strobe1"}, strobes[0], 4);
         chk_int({tag, "_strobe2"}, strobes[1], 8);
         chk_int({tag, "_strobe3"}, strobes[2], 12);
      end
      chk_int({tag, "_expired_at"}, exp_k, 14);
      chk_int({tag, "_expired_cnt"}, exp_cnt, 1);
      chk({tag, "_time_up_held"}, time_up, 1'b1);
   endtask

   initial begin
      int en_cnt, exp_cnt, warn_cnt, blink_rises;
      logic prev_blink;
      resetN = 0; start = 0; pause_toggle = 0; abort = 0;
      countL = 0; countH = 0; cnt_tc = 1;
      mode = M_IDLE; rc = 0; wc = 0; first_exp = 0; load_val = 0; cval = 0;
      repeat (2) @(posedge clk);

      // reset state
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 1);   // pause_toggle ignored in IDLE
      chk("idle_after_toggle", paused, 1'b0);

      // basic countdown from 03
      run_003("cd03");

      // pause at prescaler 2, hold 10 cycles, resume
      load_val = 5;
      cyc(0, 1, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);   // third RUN cycle: prescaler at 2
      en_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 1);
         if (obs_en) en_cnt++;
      end
      chk_int("pause_no_strobe", en_cnt, 0);
      chk("pause_level", paused, 1'b1);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 1);
      chk("resume_strobe", obs_en, 1'b1);
      cyc(0, 0, 0, 1);

      // abort + start + pause_toggle together in RUN
      cyc(1, 1, 1, 1);
      cyc(0, 0, 0, 1);
      chk("abort_no_load", obs_loadN, 1'b1);
      chk("abort_idle", running, 1'b0);

      // loaded 00 expires with no strobes
      load_val = 0;
      cyc(0, 1, 0, 1);
      en_cnt = 0; exp_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 1);
         if (obs_en) en_cnt++;
         if (obs_exp) exp_cnt++;
      end
      chk_int("zero_strobes", en_cnt, 0);
      chk_int("zero_expired_once", exp_cnt, 1);
      cyc(0, 0, 1, 1);   // pause_toggle ignored in EXPIRED
      chk("expired_hold", time_up, 1'b1);

      // warning window: 11 -> 10 -> 09, then pause, then abort
      load_val = 11;
      cyc(0, 1, 0, 1);
      warn_cnt = 0; blink_rises = 0; prev_blink = 0;
      for (int i = 0; i < 22; i++) begin
         cyc(0, 0, (i == 15), 1);
         if (obs_warn) warn_cnt++;
         if (obs_blink && !prev_blink) blink_rises++;
         prev_blink = obs_blink;
      end
      chk("warn_in_pause", paused, 1'b1);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("warn_after_abort", obs_warn, 1'b0);
      chk("blink_after_abort", obs_blink, 1'b0);
`ifdef ROUND_TIMER_WARN_EN
      chk_int("warn_cycles", warn_cnt, 17);
      chk_int("blink_rises", blink_rises, 3);
`else
      chk_int("warn_cycles", warn_cnt, 0);
      chk_int("blink_rises", blink_rises, 0);
`endif

      // reset in the middle of RUN, then a clean countdown
      load_val = 7;
      cyc(0, 1, 0, 1);
      repeat (6) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("post_reset_run", running, 1'b0);
      chk("post_reset_en", obs_en, 1'b0);
      run_003("cd03_after_reset");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         logic a, s, p, r;
         a = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 29) == 0);
         p = ($urandom_range(0, 11) == 0);
         r = ($urandom_range(0, 299) != 0);
         if (s) load_val = $urandom_range(0, 14);
         cyc(a, s, p, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
